// File: rtl/rv_defs_pkg.sv
// rtl/rv_defs_pkg.sv - shared RV32 opcode, exception and immediate-format definitions
package rv_defs_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] NOP_INST = 32'h0000_0033;

    localparam logic [4:0] EXC_IAM = 5'd0;
    localparam logic [4:0] EXC_IAF = 5'd1;
    localparam logic [4:0] EXC_ILL = 5'd2;
    // Flag bit set marks the code as a live exception.
    localparam logic [5:0] EXC_ILL_CODE = {1'b1, EXC_ILL};

    typedef enum logic [2:0] {
        IMM_R,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_BAD
    } imm_type_e;

    function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: imm_type_of = IMM_I;
            OP_STORE:                           imm_type_of = IMM_S;
            OP_BRANCH:                          imm_type_of = IMM_B;
            OP_LUI, OP_AUIPC:                   imm_type_of = IMM_U;
            OP_JAL:                             imm_type_of = IMM_J;
            OP_REG:                             imm_type_of = IMM_R;
            default:                            imm_type_of = IMM_BAD;
        endcase
    endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// rtl/rv_imm_gen.sv - combinational immediate, operand-use and illegal-opcode decode
module rv_imm_gen
    import rv_defs_pkg::*;
(
    input  logic [31:0] inst,
    output logic [31:0] imm,
    output logic        uses_rs1,
    output logic        uses_rs2,
    output logic        illegal
);

    imm_type_e imm_type;

    assign imm_type = imm_type_of(inst[6:0]);

    always_comb begin
        imm      = '0;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        illegal  = 1'b0;
        case (imm_type)
            IMM_I: imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S: begin
                imm      = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                uses_rs2 = 1'b1;
            end
            IMM_B: begin
                imm      = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                uses_rs2 = 1'b1;
            end
            IMM_U: begin
                imm      = {inst[31:12], 12'b0};
                uses_rs1 = 1'b0;
            end
            IMM_J: begin
                imm      = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                uses_rs1 = 1'b0;
            end
            IMM_R:   uses_rs2 = 1'b1;
            default: illegal  = 1'b1;
        endcase
        // SYSTEM shares the I format but never reads rs1 here.
        if (inst[6:0] == OP_SYSTEM) begin
            uses_rs1 = 1'b0;
        end
    end

endmodule

// File: rtl/id_fetch_receiver.sv
// rtl/id_fetch_receiver.sv - decode-side fetch->decode pipeline register with load-use stall
module id_fetch_receiver
    import rv_defs_pkg::*;
#(
    parameter logic [31:0] NOP_INST = rv_defs_pkg::NOP_INST,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fs_to_ds_valid,
    input  logic [63:0]      if_id_bus_in,
    input  logic [5:0]       exception_code_fd,
    output logic             ds_allowin,
    input  logic             flush,
    input  logic             es_allowin,
    input  logic             es_valid,
    input  logic             es_is_load,
    input  logic [4:0]       es_rd,
    output logic             ds_to_es_valid,
    output logic [31:0]      ds_pc,
    output logic [31:0]      ds_inst,
    output logic [4:0]       ds_rs1,
    output logic [4:0]       ds_rs2,
    output logic [4:0]       ds_rd,
    output logic [2:0]       ds_funct3,
    output logic [6:0]       ds_funct7,
    output logic [31:0]      ds_imm,
    output logic             ds_uses_rs1,
    output logic             ds_uses_rs2,
    output logic [5:0]       exception_code_dd,
    output logic [CNT_W-1:0] stall_cnt
);

    logic        ds_valid;
    logic [31:0] inst_r;
    logic [31:0] pc_r;
    logic [5:0]  exc_r;
    logic        illegal;
    logic        load_use;
    logic        ds_ready_go;

    rv_imm_gen u_imm_gen (
        .inst     (inst_r),
        .imm      (ds_imm),
        .uses_rs1 (ds_uses_rs1),
        .uses_rs2 (ds_uses_rs2),
        .illegal  (illegal)
    );

    assign ds_inst   = inst_r;
    assign ds_pc     = pc_r;
    assign ds_rs1    = inst_r[19:15];
    assign ds_rs2    = inst_r[24:20];
    assign ds_rd     = inst_r[11:7];
    assign ds_funct3 = inst_r[14:12];
    assign ds_funct7 = inst_r[31:25];

    // x0 is never a real producer, so a load to x0 cannot create a hazard.
    assign load_use = ds_valid && es_valid && es_is_load && (es_rd != 5'd0) &&
                      ((ds_uses_rs1 && (ds_rs1 == es_rd)) ||
                       (ds_uses_rs2 && (ds_rs2 == es_rd)));

    assign ds_ready_go    = !load_use;
    assign ds_allowin     = !ds_valid || (ds_ready_go && es_allowin);
    assign ds_to_es_valid = ds_valid && ds_ready_go && !flush;

    always_comb begin
        exception_code_dd = 6'd0;
        if (ds_valid) begin
            // A live fetch exception takes precedence over the illegal-opcode code.
            if (illegal && !exc_r[5]) begin
                exception_code_dd = EXC_ILL_CODE;
            end else begin
                exception_code_dd = exc_r;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ds_valid  <= 1'b0;
            inst_r    <= NOP_INST;
            pc_r      <= 32'd0;
            exc_r     <= 6'd0;
            stall_cnt <= '0;
        end else begin
            if (flush) begin
                ds_valid <= 1'b0;
            end else if (ds_allowin) begin
                ds_valid <= fs_to_ds_valid;
                if (fs_to_ds_valid) begin
                    inst_r <= if_id_bus_in[63:32];
                    pc_r   <= if_id_bus_in[31:0];
                    exc_r  <= exception_code_fd;
                end
            end
            if (load_use) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule
